// File: rtl/z_stream_packer.sv
// z_stream_packer
// Packs a serial bit stream (one bit per qualified cycle) LSB-first into
// WIDTH-bit words and presents them on a valid/ready port together with
// a population count. Two words of storage: one in the output register
// and one in the shift register. Bits offered while both are full are
// dropped and recorded in a sticky overflow flag.

module z_stream_packer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             word_ready,
  input  logic             ovf_clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic [CNT_W-1:0] ones_count,
  output logic             overflow
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [CNT_W-1:0] cnt;

  logic             drain;
  logic             out_free;
  logic             last_bit;
  logic             drop;
  logic [WIDTH-1:0] collect_word;

  // Number of ones in a word; the result fits because 2^CNT_W > WIDTH.
  function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] w);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < WIDTH; i++) begin
      n = n + CNT_W'(w[i]);
    end
    return n;
  endfunction

  // The output register can take a new word when empty or being consumed now.
  assign drain        = word_valid & word_ready;
  assign out_free     = ~word_valid | drain;
  assign last_bit     = (cnt == CNT_W'(WIDTH - 1));
  assign drop         = (state == HOLD) & ~out_free & bit_valid;
  // Word completed directly from the incoming bit, bypassing sr[WIDTH-1].
  assign collect_word = {bit_in, sr[WIDTH-2:0]};

  // Packing FSM: collects bits into sr, moves complete words into the output register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= COLLECT;
      sr         <= '0;
      cnt        <= '0;
      word_out   <= '0;
      ones_count <= '0;
      word_valid <= 1'b0;
    end else begin
      // A consumed word empties the output unless a new word loads below.
      if (drain) begin
        word_valid <= 1'b0;
      end

      case (state)
        COLLECT: begin
          if (bit_valid) begin
            if (last_bit && out_free) begin
              // Final bit goes straight to the output together with sr.
              word_out   <= collect_word;
              ones_count <= popcount(collect_word);
              word_valid <= 1'b1;
              cnt        <= '0;
            end else begin
              for (int i = 0; i < WIDTH; i++) begin
                if (cnt == CNT_W'(i)) begin
                  sr[i] <= bit_in;
                end
              end
              if (last_bit) begin
                // sr now holds a complete word that must wait for the output.
                state <= HOLD;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
        end

        HOLD: begin
          if (out_free) begin
            word_out   <= sr;
            ones_count <= popcount(sr);
            word_valid <= 1'b1;
            state      <= COLLECT;
            // The transfer cycle can still accept the first bit of the next word.
            if (bit_valid) begin
              sr[0] <= bit_in;
              cnt   <= CNT_W'(1);
            end else begin
              cnt   <= '0;
            end
          end
        end

        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  // Sticky overflow: a drop wins over a clear in the same cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clear) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_z_stream_packer.sv
// Directed testbench for z_stream_packer (WIDTH=8, CNT_W=4).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_z_stream_packer;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clock;
  logic             reset;
  logic             bit_in;
  logic             bit_valid;
  logic             word_ready;
  logic             ovf_clear;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic [CNT_W-1:0] ones_count;
  logic             overflow;

  int vectors;
  int miscompares;

  z_stream_packer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bit_in    (bit_in),
    .bit_valid (bit_valid),
    .word_ready(word_ready),
    .ovf_clear (ovf_clear),
    .word_out  (word_out),
    .word_valid(word_valid),
    .ones_count(ones_count),
    .overflow  (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one bit and clock it in.
  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    step();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    word_ready = 1'b0;
    ovf_clear  = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({word_out, ones_count, word_valid, overflow} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got word=%h cnt=%0d vld=%b ovf=%b, want all 0",
               word_out, ones_count, word_valid, overflow);
    end
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [7:0] bits;
    bits = 8'h8D;
    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(bits[i]);
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_early_valid: got %b, want 0", word_valid);
    end
    send_bit(bits[7]);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'h8D || ones_count !== 4'd4) begin
      miscompares++;
      $display("FAIL single_word: got vld=%b word=%h cnt=%0d, want vld=1 word=8d cnt=4",
               word_valid, word_out, ones_count);
    end
    step();
    vectors++;
    if (word_valid !== 1'b0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL single_one_cycle: got vld=%b ovf=%b, want vld=0 ovf=0",
               word_valid, overflow);
    end
  endtask

  task automatic test_gapped();
    logic [7:0] bits;
    bits = 8'h8D;
    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send_bit(bits[i]);
      step();
    end
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_early_valid: got %b, want 0", word_valid);
    end
    send_bit(bits[7]);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'h8D || ones_count !== 4'd4) begin
      miscompares++;
      $display("FAIL gapped_word: got vld=%b word=%h cnt=%0d, want vld=1 word=8d cnt=4",
               word_valid, word_out, ones_count);
    end
    step();
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL gapped_drain: got vld=%b, want 0", word_valid);
    end
  endtask

  task automatic test_backpressure();
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'hFF || ones_count !== 4'd8) begin
      miscompares++;
      $display("FAIL bp_first_word: got vld=%b word=%h cnt=%0d, want vld=1 word=ff cnt=8",
               word_valid, word_out, ones_count);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_16_no_ovf: got ovf=%b, want 0", overflow);
    end
    send_bit(1'b1);
    vectors++;
    if (overflow !== 1'b1 || word_out !== 8'hFF || word_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_17_drop: got ovf=%b word=%h vld=%b, want ovf=1 word=ff vld=1",
               overflow, word_out, word_valid);
    end
    word_ready = 1'b1;
    step();
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'hFF || ones_count !== 4'd8) begin
      miscompares++;
      $display("FAIL bp_second_word: got vld=%b word=%h cnt=%0d, want vld=1 word=ff cnt=8",
               word_valid, word_out, ones_count);
    end
    step();
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_all_drained: got vld=%b, want 0", word_valid);
    end
    word_ready = 1'b0;
    ovf_clear  = 1'b1;
    step();
    ovf_clear  = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear_alone: got ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_transfer_accept();
    logic [7:0] w1;
    logic [7:0] w2;
    w1 = 8'h03;
    w2 = 8'hA5;
    word_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(w1[i]);
    for (int i = 0; i < 8; i++) send_bit(w2[i]);
    vectors++;
    if (word_out !== 8'h03 || ones_count !== 4'd2) begin
      miscompares++;
      $display("FAIL xfer_first: got word=%h cnt=%0d, want word=03 cnt=2", word_out, ones_count);
    end
    word_ready = 1'b1;
    send_bit(1'b1);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'hA5 || ones_count !== 4'd4 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL xfer_load: got vld=%b word=%h cnt=%0d ovf=%b, want vld=1 word=a5 cnt=4 ovf=0",
               word_valid, word_out, ones_count, overflow);
    end
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL xfer_partial: got vld=%b, want 0", word_valid);
    end
    send_bit(1'b0);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'h01 || ones_count !== 4'd1) begin
      miscompares++;
      $display("FAIL xfer_next_word: got vld=%b word=%h cnt=%0d, want vld=1 word=01 cnt=1",
               word_valid, word_out, ones_count);
    end
    step();
  endtask

  task automatic test_ovf_clear_vs_drop();
    word_ready = 1'b0;
    for (int i = 0; i < 16; i++) send_bit(1'b0);
    ovf_clear = 1'b1;
    send_bit(1'b0);
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_set_wins: got ovf=%b, want 1", overflow);
    end
    step();
    ovf_clear = 1'b0;
    vectors++;
    if (overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_clear_after: got ovf=%b, want 0", overflow);
    end
    word_ready = 1'b1;
    step();
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'h00 || ones_count !== 4'd0) begin
      miscompares++;
      $display("FAIL ovf_zero_word: got vld=%b word=%h cnt=%0d, want vld=1 word=00 cnt=0",
               word_valid, word_out, ones_count);
    end
    step();
  endtask

  task automatic test_async_reset();
    logic [7:0] w;
    w = 8'h01;
    word_ready = 1'b0;
    for (int i = 0; i < 13; i++) send_bit(1'b1);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'hFF) begin
      miscompares++;
      $display("FAIL rst_pre: got vld=%b word=%h, want vld=1 word=ff", word_valid, word_out);
    end
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if ({word_out, ones_count, word_valid, overflow} !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got word=%h cnt=%0d vld=%b ovf=%b, want all 0",
               word_out, ones_count, word_valid, overflow);
    end
    #2;
    reset = 1'b1;
    step();
    word_ready = 1'b1;
    for (int i = 0; i < 7; i++) send_bit(w[i]);
    vectors++;
    if (word_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_partial_discarded: got vld=%b, want 0", word_valid);
    end
    send_bit(w[7]);
    vectors++;
    if (word_valid !== 1'b1 || word_out !== 8'h01 || ones_count !== 4'd1) begin
      miscompares++;
      $display("FAIL rst_next_word: got vld=%b word=%h cnt=%0d, want vld=1 word=01 cnt=1",
               word_valid, word_out, ones_count);
    end
    step();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_word();
    test_gapped();
    test_backpressure();
    test_transfer_accept();
    test_ovf_clear_vs_drop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
